// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: WIDTH bits resolved CHUNK bits per stage over STAGES carry-chained stages,
// with a globally stalled valid/ready handshake and registered sum, carry-out, overflow and zero flags.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Stage registers: operands (B already conditioned), partial sum, carry and valid.
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_carry [STAGES];
  logic             r_valid [STAGES];
  logic             r_overflow;
  logic             r_zero;

  // Per-stage inputs (predecessor register or the new operation) and the slice result.
  logic [WIDTH-1:0] w_src_a   [STAGES];
  logic [WIDTH-1:0] w_src_b   [STAGES];
  logic [WIDTH-1:0] w_src_sum [STAGES];
  logic             w_src_c   [STAGES];
  logic             w_src_v   [STAGES];
  logic [WIDTH-1:0] w_nxt_sum [STAGES];
  logic             w_nxt_c   [STAGES];
  logic [CHUNK:0]   w_slice;
  logic             w_advance;
  logic             w_overflow;
  logic             w_zero;

  // The whole pipe moves together, so a full output register freezes every stage.
  assign w_advance = !r_valid[LAST] || out_ready;
  assign in_ready  = w_advance;

  always_comb begin : stage_inputs
    w_src_a[0]   = a;
    w_src_b[0]   = sub ? ~b : b;
    w_src_sum[0] = '0;
    w_src_c[0]   = sub;
    w_src_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_src_a[k]   = r_a[k-1];
      w_src_b[k]   = r_b[k-1];
      w_src_sum[k] = r_sum[k-1];
      w_src_c[k]   = r_carry[k-1];
      w_src_v[k]   = r_valid[k-1];
    end
  end

  // NOTE: every combinational output is assigned on every path before use, so no latch is inferred.
  always_comb begin : slice_add
    w_slice = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_slice = {1'b0, w_src_a[k][k*CHUNK +: CHUNK]}
              + {1'b0, w_src_b[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, w_src_c[k]};
      w_nxt_sum[k]                  = w_src_sum[k];
      w_nxt_sum[k][k*CHUNK +: CHUNK] = w_slice[CHUNK-1:0];
      w_nxt_c[k]                    = w_slice[CHUNK];
    end
  end

  assign w_overflow = (w_src_a[LAST][WIDTH-1] == w_src_b[LAST][WIDTH-1])
                   && (w_nxt_sum[LAST][WIDTH-1] != w_src_a[LAST][WIDTH-1]);
  assign w_zero     = ~|w_nxt_sum[LAST];

  // NOTE: only valid bits and the visible output fields are reset; inner data fields
  // are qualified by their valid bit, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_valid[k] <= 1'b0;
      r_sum[LAST]   <= '0;
      r_carry[LAST] <= 1'b0;
      r_overflow    <= 1'b0;
      r_zero        <= 1'b0;
    end else if (w_advance) begin
      for (int k = 0; k < LAST; k++) begin
        r_valid[k] <= w_src_v[k];
        r_a[k]     <= w_src_a[k];
        r_b[k]     <= w_src_b[k];
        r_sum[k]   <= w_nxt_sum[k];
        r_carry[k] <= w_nxt_c[k];
      end
      r_valid[LAST] <= w_src_v[LAST];
      // Bubbles leave the previous result on the outputs instead of exposing junk.
      if (w_src_v[LAST]) begin
        r_sum[LAST]   <= w_nxt_sum[LAST];
        r_carry[LAST] <= w_nxt_c[LAST];
        r_overflow    <= w_overflow;
        r_zero        <= w_zero;
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum       = r_sum[LAST];
  assign cout      = r_carry[LAST];
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: three instances (8/1, 32/4, 64/8) exercised one at a time
// against an arithmetic reference model; a separate monitor pops expectations on each delivery.
module tb_pipe_adder;

  typedef struct {
    int          dut;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ivalid [3];
  logic        oready [3];
  logic        sub_d  [3];
  logic [63:0] a_d    [3];
  logic [63:0] b_d    [3];
  logic        ird    [3];
  logic        ov     [3];
  logic        co     [3];
  logic        of     [3];
  logic        zr     [3];
  logic [7:0]  sum0;
  logic [31:0] sum1;
  logic [63:0] sum2;

  exp_t sb_q [$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   deliv_cnt = 0;
  int   first_cyc = 0;
  int   last_cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(ivalid[0]), .in_ready(ird[0]),
    .a(a_d[0][7:0]), .b(b_d[0][7:0]), .sub(sub_d[0]),
    .out_valid(ov[0]), .out_ready(oready[0]), .sum(sum0),
    .cout(co[0]), .overflow(of[0]), .zero(zr[0]));

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(ivalid[1]), .in_ready(ird[1]),
    .a(a_d[1][31:0]), .b(b_d[1][31:0]), .sub(sub_d[1]),
    .out_valid(ov[1]), .out_ready(oready[1]), .sum(sum1),
    .cout(co[1]), .overflow(of[1]), .zero(zr[1]));

  pipe_adder #(.WIDTH(64), .STAGES(8)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(ivalid[2]), .in_ready(ird[2]),
    .a(a_d[2]), .b(b_d[2]), .sub(sub_d[2]),
    .out_valid(ov[2]), .out_ready(oready[2]), .sum(sum2),
    .cout(co[2]), .overflow(of[2]), .zero(zr[2]));

  function automatic int wid(int d);
    case (d)
      0:       return 8;
      1:       return 32;
      default: return 64;
    endcase
  endfunction

  function automatic int stg(int d);
    case (d)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] mask(int d);
    if (wid(d) == 64) return '1;
    return (64'd1 << wid(d)) - 64'd1;
  endfunction

  function automatic logic [63:0] get_sum(int d);
    case (d)
      0:       return {56'd0, sum0};
      1:       return {32'd0, sum1};
      default: return sum2;
    endcase
  endfunction

  function automatic logic signed [65:0] sext(logic [63:0] x, int w);
    logic signed [65:0] r;
    r = $signed({2'b00, x});
    if (x[w-1]) r = r - $signed({1'b0, 65'd1 << w});
    return r;
  endfunction

  // Reference: plain integer arithmetic on the operand values, no slicing or carry chain.
  function automatic exp_t model(int d, logic [63:0] av, logic [63:0] bv, logic s);
    exp_t               e;
    int                 w;
    logic signed [65:0] sa, sb, res, hi, lo;
    w      = wid(d);
    e.dut  = d;
    e.sum  = (s ? av - bv : av + bv) & mask(d);
    if (s) e.cout = (av >= bv);
    else   e.cout = (({1'b0, av} + {1'b0, bv}) > {1'b0, mask(d)});
    sa     = sext(av, w);
    sb     = sext(bv, w);
    res    = s ? sa - sb : sa + sb;
    hi     = (66'sd1 <<< (w - 1)) - 66'sd1;
    lo     = -(66'sd1 <<< (w - 1));
    e.ovf  = (res > hi) || (res < lo);
    e.zero = (e.sum == 64'd0);
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic string tag(int d, string name);
    return $sformatf("d%0d_%s", d, name);
  endfunction

  // Monitor: every delivery pops the oldest expectation and compares all result fields.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && oready[d]) begin
          if (sb_q.size() == 0 || sb_q[0].dut != d) begin
            checks++;
            failures++;
            $display("FAIL d%0d_unexpected_result: got sum %h expected no result", d, get_sum(d));
          end else begin
            e = sb_q.pop_front();
            check(tag(d, "sum"),  get_sum(d),  e.sum);
            check(tag(d, "cout"), 64'(co[d]),  64'(e.cout));
            check(tag(d, "ovf"),  64'(of[d]),  64'(e.ovf));
            check(tag(d, "zero"), 64'(zr[d]),  64'(e.zero));
            deliv_cnt++;
            if (deliv_cnt == 1) first_cyc = cyc;
            last_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic present(int d, logic [63:0] av, logic [63:0] bv, logic s);
    a_d[d]    = av & mask(d);
    b_d[d]    = bv & mask(d);
    sub_d[d]  = s;
    ivalid[d] = 1'b1;
  endtask

  task automatic await_accept(int d);
    int t = 0;
    @(negedge clk);
    while (!ird[d] && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ird[d]) begin
      checks++;
      failures++;
      $display("FAIL d%0d_accept_timeout: in_ready stayed %0d expected 1", d, ird[d]);
    end else begin
      sb_q.push_back(model(d, a_d[d], b_d[d], sub_d[d]));
    end
    @(posedge clk);
    #1;
    ivalid[d] = 1'b0;
  endtask

  task automatic issue(int d, logic [63:0] av, logic [63:0] bv, logic s);
    present(d, av, bv, s);
    await_accept(d);
  endtask

  task automatic rand_issue(int d);
    issue(d, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(int d);
    int t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check(tag(d, "drain_pending"), 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic latency(int d, logic [63:0] av, logic [63:0] bv, logic s);
    int k;
    issue(d, av, bv, s);
    k = 1;
    while (!ov[d] && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag(d, "latency"), 64'(k), 64'(stg(d)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ivalid[i] = 1'b0;
      oready[i] = 1'b1;
      sub_d[i]  = 1'b0;
      a_d[i]    = '0;
      b_d[i]    = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_suite(int d);
    logic [63:0] m, msb;
    m   = mask(d);
    msb = 64'd1 << (wid(d) - 1);
    do_reset();
    check(tag(d, "rst_out_valid"), 64'(ov[d]),  64'd0);
    check(tag(d, "rst_sum"),       get_sum(d),  64'd0);
    check(tag(d, "rst_flags"),     {61'd0, co[d], of[d], zr[d]}, 64'd0);
    check(tag(d, "rst_in_ready"),  64'(ird[d]), 64'd1);

    latency(d, 64'd5, 64'd3, 1'b0);
    issue(d, 64'd5, 64'd5, 1'b1);
    issue(d, 64'd3, 64'd5, 1'b1);
    issue(d, msb, 64'd1, 1'b1);
    issue(d, m, 64'd1, 1'b0);
    issue(d, msb - 64'd1, 64'd1, 1'b0);
    drain(d);

    deliv_cnt = 0;
    for (int i = 0; i < 16; i++) rand_issue(d);
    drain(d);
    check(tag(d, "stream_count"), 64'(deliv_cnt), 64'd16);
    check(tag(d, "stream_span"),  64'(last_cyc - first_cyc), 64'd15);

    // Fill the pipe with out_ready low, then hold an extra operand against the stall.
    deliv_cnt = 0;
    oready[d] = 1'b0;
    for (int i = 0; i < stg(d); i++) rand_issue(d);
    present(d, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(tag(d, "stall_in_ready"),  64'(ird[d]), 64'd0);
      check(tag(d, "stall_out_valid"), 64'(ov[d]),  64'd1);
      if (sb_q.size() > 0) begin
        check(tag(d, "stall_sum"),   get_sum(d), sb_q[0].sum);
        check(tag(d, "stall_flags"), {61'd0, co[d], of[d], zr[d]},
              {61'd0, sb_q[0].cout, sb_q[0].ovf, sb_q[0].zero});
      end
      @(posedge clk);
      #1;
    end
    oready[d] = 1'b1;
    await_accept(d);
    drain(d);
    check(tag(d, "stall_count"), 64'(deliv_cnt), 64'(stg(d) + 1));

    for (int i = 0; i < 3; i++) rand_issue(d);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    check(tag(d, "midrst_out_valid"), 64'(ov[d]), 64'd0);
    check(tag(d, "midrst_sum"),       get_sum(d), 64'd0);
    rst = 1'b0;
    check(tag(d, "midrst_in_ready"),  64'(ird[d]), 64'd1);
    latency(d, 64'd2, 64'd2, 1'b0);
    drain(d);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      ivalid[i] = 1'b0;
      oready[i] = 1'b1;
      sub_d[i]  = 1'b0;
      a_d[i]    = '0;
      b_d[i]    = '0;
    end
    for (int d = 0; d < 3; d++) run_suite(d);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
